// File: rtl/gpio_pkg.sv
// Shared defaults and widths for the GPIO input monitor.
package gpio_pkg;

  localparam int NUM_CH_DEF          = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int EDGE_CNT_W          = 16;
  localparam int DB_CNT_W            = $clog2(DEBOUNCE_CYCLES_DEF + 1);

  function automatic int db_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_in_monitor_if.sv
// Pin-side and status-side signals of the GPIO input monitor.
interface gpio_in_monitor_if
  import gpio_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
) ();

  logic [NUM_CH-1:0]     gpio_in;
  logic                  clear;
  logic                  mode;
  logic [NUM_CH-1:0]     led;
  logic                  led_any;
  logic [NUM_CH-1:0]     level;
  logic [NUM_CH-1:0]     rise;
  logic [NUM_CH-1:0]     fall;
  logic [EDGE_CNT_W-1:0] edge_count;

  modport master (
    output gpio_in, clear, mode,
    input  led, led_any, level, rise, fall, edge_count
  );

  modport slave (
    input  gpio_in, clear, mode,
    output led, led_any, level, rise, fall, edge_count
  );

endinterface

// File: rtl/gpio_debounce.sv
// One GPIO channel: 2-flop synchronizer, mismatch counter, debounced level
// and single-cycle rise/fall pulses.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int               CNT_W    = db_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             w_diff;
  logic             w_flip;

  // The edge that closes the DEBOUNCE_CYCLES-th mismatching cycle flips the level.
  assign w_diff = r_sync_p1 ^ r_level;
  assign w_flip = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_sync_p0 <= i_pin;
      r_sync_p1 <= r_sync_p0;
      if (!w_diff || w_flip) r_cnt <= '0;
      else                   r_cnt <= r_cnt + 1'b1;
      if (w_flip) r_level <= ~r_level;
      r_rise <= w_flip & ~r_level;
      r_fall <= w_flip &  r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/gpio_in_monitor.sv
// GPIO input monitor: per-channel debounce, sticky edge flags, saturating
// rising-edge counter and a mode-selected LED display.
module gpio_in_monitor
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int NUM_CH          = NUM_CH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  gpio_in_monitor_if.slave  bus
);

  logic [NUM_CH-1:0]     w_level;
  logic [NUM_CH-1:0]     w_rise;
  logic [NUM_CH-1:0]     w_fall;
  logic [EDGE_CNT_W-1:0] w_pop;
  logic [EDGE_CNT_W-1:0] w_edge_next;

  logic                  r_clr_p0;
  logic                  r_clr_p1;
  logic                  r_mode_p0;
  logic                  r_mode_p1;
  logic [NUM_CH-1:0]     r_flag;
  logic [EDGE_CNT_W-1:0] r_edge_count;
  logic [NUM_CH-1:0]     r_led;
  logic                  r_led_any;

  function automatic logic [EDGE_CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [EDGE_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CH; i++) n = n + EDGE_CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [EDGE_CNT_W-1:0] sat_add(input logic [EDGE_CNT_W-1:0] a,
                                                    input logic [EDGE_CNT_W-1:0] b);
    logic [EDGE_CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[EDGE_CNT_W] ? '1 : s[EDGE_CNT_W-1:0];
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gpio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_pin   (bus.gpio_in[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g]),
      .o_fall  (w_fall[g])
    );
  end

  // A clear cycle restarts the count from this cycle's rises rather than dropping them.
  assign w_pop       = popcount(w_rise);
  assign w_edge_next = r_clr_p1 ? w_pop : sat_add(r_edge_count, w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_p0     <= 1'b0;
      r_clr_p1     <= 1'b0;
      r_mode_p0    <= 1'b0;
      r_mode_p1    <= 1'b0;
      r_flag       <= '0;
      r_edge_count <= '0;
      r_led        <= '0;
      r_led_any    <= 1'b0;
    end else begin
      r_clr_p0     <= bus.clear;
      r_clr_p1     <= r_clr_p0;
      r_mode_p0    <= bus.mode;
      r_mode_p1    <= r_mode_p0;
      r_flag       <= (r_flag & ~{NUM_CH{r_clr_p1}}) | w_rise | w_fall;
      r_edge_count <= w_edge_next;
      r_led        <= r_mode_p1 ? r_flag : w_level;
      r_led_any    <= |r_flag;
    end
  end

  assign bus.led        = r_led;
  assign bus.led_any    = r_led_any;
  assign bus.level      = w_level;
  assign bus.rise       = w_rise;
  assign bus.fall       = w_fall;
  assign bus.edge_count = r_edge_count;

endmodule

// File: doc/gpio_in_monitor.md
GPIO_IN_MONITOR -- requirements
Module: gpio_in_monitor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive clk cycles a synchronized input must differ from its debounced level before the level changes; 1 ms at 50 MHz; legal range 2..2^20.
REQ-002 Parameter NUM_CH, default 8: number of GPIO input channels.
REQ-003 clk  input  1  system clock, 50 MHz; the single clock domain.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 gpio_in  input  NUM_CH  raw GPIO header pins, asynchronous to clk.
REQ-006 clear  input  1  board key, asynchronous, active-high; clears sticky flags and edge_count.
REQ-007 mode  input  1  board switch, asynchronous; 0 = led shows debounced levels, 1 = led shows sticky edge flags.
REQ-008 led  output  NUM_CH  per-channel display, selected by mode.
REQ-009 led_any  output  1  OR of all sticky flags.
REQ-010 level  output  NUM_CH  debounced input levels.
REQ-011 rise  output  NUM_CH  one-cycle pulse per channel on each debounced 0->1 transition.
REQ-012 fall  output  NUM_CH  one-cycle pulse per channel on each debounced 1->0 transition.
REQ-013 edge_count  output  16  saturating count of debounced rising edges, summed across all channels.

Function
REQ-014 Each gpio_in bit, clear and mode SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-015 Each channel SHALL hold a debounce counter that increments every cycle its synchronized input differs from level, and resets to 0 on any cycle where they match.
REQ-016 On the clk edge where the counter has counted DEBOUNCE_CYCLES consecutive mismatching cycles, level SHALL toggle and the counter SHALL return to 0 on that same edge.
REQ-017 Total latency from a stable pin change to the level change SHALL be 2 + DEBOUNCE_CYCLES clk cycles; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no level change.
REQ-018 rise/fall SHALL be registered and assert for exactly the one cycle immediately after the level transition edge; they are never both high on the same channel.
REQ-019 Sticky flag[i] SHALL set on rise[i] or fall[i] and hold until synchronized clear is high.
REQ-020 When a set and a clear coincide on one channel in the same cycle, set SHALL win.
REQ-021 edge_count SHALL add popcount(rise) each cycle and saturate at 16'hFFFF with no wrap-around.
REQ-022 When clear coincides with rise pulses, edge_count SHALL load popcount(rise).
REQ-023 When clear is high with no rise pulses, edge_count SHALL load 0.
REQ-024 led SHALL be registered: mode 0 selects level, mode 1 selects the sticky flags; a mode change appears within 3 cycles.
REQ-025 led_any SHALL be registered, with one cycle of latency after the sticky flags.

Reset
REQ-026 While rst_n is low, all synchronizer flops, counters, level, rise, fall, sticky flags, edge_count, led and led_any SHALL be 0.
REQ-027 After rst_n deasserts, an input that is already high SHALL debounce normally and produce one rise pulse 2 + DEBOUNCE_CYCLES cycles later.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count, with no rise/fall pulse emitted.

Structure
REQ-029 Package gpio_pkg SHALL hold NUM_CH default, DEBOUNCE_CYCLES default, the edge_count width (16) and the debounce counter width (clog2(DEBOUNCE_CYCLES+1)).
REQ-030 Sub-module gpio_debounce (one channel: synchronizer, counter, level, rise, fall) SHALL be instantiated NUM_CH times.
REQ-031 The top level SHALL hold the clear/mode synchronizers, sticky flags, popcount adder, saturating counter and led mux.

Verification (DEBOUNCE_CYCLES=4, NUM_CH=8)
REQ-032 gpio_in[0] 0->1 held -> level[0]=1 exactly 6 cycles later; rise[0] high 1 cycle; edge_count=1.
REQ-033 gpio_in[3] high for 3 cycles then low -> level, rise and fall stay 0; edge_count unchanged.
REQ-034 All 8 inputs rise in the same cycle -> rise=8'hFF for 1 cycle; edge_count +8; with mode=1, led=8'hFF and led_any=1.
REQ-035 edge_count preloaded near 16'hFFFE, then 4 simultaneous rises -> edge_count=16'hFFFF, holds at that value.
REQ-036 clear synchronized onto the same cycle as rise[2] -> flag[2]=1 and edge_count=1; all other flags 0.
REQ-037 rst_n low during cycle 3 of a debounce -> all outputs 0; no pulse; with the input still high after release, rise appears 6 cycles later.
